// File: rtl/fpro_bus_arbiter.sv
// Two-master round-robin / fixed-priority arbiter in front of the FPro slave bus.
// Each grant is one registered bus cycle (GRANT) followed by a one-cycle done pulse (ACK).
module fpro_bus_arbiter #(
    parameter int ADDR_W     = 21,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_video,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_done,
    input  logic              m1_req,
    input  logic              m1_video,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_done,
    output logic              busy,
    output logic              fp_video_cs,
    output logic              fp_mmio_cs,
    output logic              fp_wr,
    output logic              fp_rd,
    output logic [ADDR_W-1:0] fp_addr,
    output logic [DATA_W-1:0] fp_wr_data,
    input  logic [DATA_W-1:0] fp_rd_data
);

    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

    state_t              state_reg, state_next;
    logic                rr_ptr_reg, rr_ptr_next;
    logic                win_reg, win_next;
    logic                video_cs_reg, video_cs_next;
    logic                mmio_cs_reg, mmio_cs_next;
    logic                wr_reg, wr_next;
    logic                rd_reg, rd_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
    logic [1:0]          done_reg, done_next;
    logic [DATA_W-1:0]   rd_data_reg [2];
    logic                pick;
    logic                any_req;

    assign any_req = m0_req | m1_req;

    // Winner when in IDLE: 0 = master 0, 1 = master 1.
    always_comb begin
        pick = ~m0_req;
        if (FIXED_PRIO == 0 && m0_req && m1_req)
            pick = rr_ptr_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= 1'b0;
            win_reg      <= 1'b0;
            video_cs_reg <= 1'b0;
            mmio_cs_reg  <= 1'b0;
            wr_reg       <= 1'b0;
            rd_reg       <= 1'b0;
            addr_reg     <= '0;
            wr_data_reg  <= '0;
            done_reg     <= 2'b00;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            win_reg      <= win_next;
            video_cs_reg <= video_cs_next;
            mmio_cs_reg  <= mmio_cs_next;
            wr_reg       <= wr_next;
            rd_reg       <= rd_next;
            addr_reg     <= addr_next;
            wr_data_reg  <= wr_data_next;
            done_reg     <= done_next;
        end
    end

    // Bus and done registers default to zero so they are only ever high for one cycle.
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        win_next      = win_reg;
        video_cs_next = 1'b0;
        mmio_cs_next  = 1'b0;
        wr_next       = 1'b0;
        rd_next       = 1'b0;
        addr_next     = '0;
        wr_data_next  = '0;
        done_next     = 2'b00;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    win_next      = pick;
                    video_cs_next = pick ? m1_video : m0_video;
                    mmio_cs_next  = ~(pick ? m1_video : m0_video);
                    wr_next       = pick ? m1_wr : m0_wr;
                    rd_next       = ~(pick ? m1_wr : m0_wr);
                    addr_next     = pick ? m1_addr : m0_addr;
                    wr_data_next  = pick ? m1_wr_data : m0_wr_data;
                    state_next    = GRANT;
                end
            end
            GRANT: begin
                done_next[win_reg] = 1'b1;
                rr_ptr_next        = ~win_reg;
                state_next         = ACK;
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read data is captured at the end of the GRANT cycle and held until the next read.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                rd_data_reg[gi] <= '0;
            else if (state_reg == GRANT && rd_reg && win_reg == 1'(gi))
                rd_data_reg[gi] <= fp_rd_data;
        end
    end

    assign m0_rd_data  = rd_data_reg[0];
    assign m1_rd_data  = rd_data_reg[1];
    assign m0_done     = done_reg[0];
    assign m1_done     = done_reg[1];
    assign busy        = (state_reg != IDLE);
    assign fp_video_cs = video_cs_reg;
    assign fp_mmio_cs  = mmio_cs_reg;
    assign fp_wr       = wr_reg;
    assign fp_rd       = rd_reg;
    assign fp_addr     = addr_reg;
    assign fp_wr_data  = wr_data_reg;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Bench for fpro_bus_arbiter: a round-robin and a fixed-priority instance share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_fpro_bus_arbiter;
    localparam int AW = 21;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          m0_req, m0_video, m0_wr, m1_req, m1_video, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wr_data, m1_wr_data;
    logic [DW-1:0] slave_data, junk;

    logic [DW-1:0] rd0 [2];
    logic [DW-1:0] rd1 [2];
    logic          done0 [2];
    logic          done1 [2];
    logic          busy [2];
    logic          vcs [2];
    logic          mcs [2];
    logic          fwr [2];
    logic          frd [2];
    logic [AW-1:0] faddr [2];
    logic [DW-1:0] fwd [2];
    logic [DW-1:0] frdd [2];

    // Slave returns slave_data only while read is strobed; anything else is junk.
    assign frdd[0] = frd[0] ? slave_data : junk;
    assign frdd[1] = frd[1] ? slave_data : junk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        fpro_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(gi)) dut (
            .clk(clk), .reset_n(reset_n),
            .m0_req(m0_req), .m0_video(m0_video), .m0_wr(m0_wr), .m0_addr(m0_addr),
            .m0_wr_data(m0_wr_data), .m0_rd_data(rd0[gi]), .m0_done(done0[gi]),
            .m1_req(m1_req), .m1_video(m1_video), .m1_wr(m1_wr), .m1_addr(m1_addr),
            .m1_wr_data(m1_wr_data), .m1_rd_data(rd1[gi]), .m1_done(done1[gi]),
            .busy(busy[gi]), .fp_video_cs(vcs[gi]), .fp_mmio_cs(mcs[gi]),
            .fp_wr(fwr[gi]), .fp_rd(frd[gi]), .fp_addr(faddr[gi]),
            .fp_wr_data(fwd[gi]), .fp_rd_data(frdd[gi])
        );
    end

    int checks = 0;
    int failures = 0;
    int ecnt = 0;
    int idle_from [2];
    int bus_edge [2];
    int done_edge [2];
    bit pref [2];
    bit win [2];
    bit pv [2];
    bit pw [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    logic [DW-1:0] exp_rd [2][2];
    int dcnt [2][2];

    task automatic chk(input string tag, input int p, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s inst%0d edge %0d: got %h expected %h", tag, p, ecnt, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            idle_from[p] = 0;
            bus_edge[p]  = -10;
            done_edge[p] = -10;
            pref[p]      = 1'b0;
            exp_rd[p][0] = '0;
            exp_rd[p][1] = '0;
        end
    endtask

    // Decide what edge e does, from the request/payload inputs present before it.
    task automatic model_edge(input int p, input int e);
        bit w;
        if (e == done_edge[p] && !pw[p])
            exp_rd[p][win[p]] = slave_data;
        if (e >= idle_from[p] && (m0_req || m1_req)) begin
            if (m0_req && m1_req)
                w = (p == 1) ? 1'b0 : pref[p];
            else
                w = !m0_req;
            pref[p]      = !w;
            win[p]       = w;
            pv[p]        = w ? m1_video : m0_video;
            pw[p]        = w ? m1_wr : m0_wr;
            pa[p]        = w ? m1_addr : m0_addr;
            pd[p]        = w ? m1_wr_data : m0_wr_data;
            bus_edge[p]  = e;
            done_edge[p] = e + 1;
            idle_from[p] = e + 3;
        end
    endtask

    task automatic check_all();
        logic [63:0] eb, ab;
        logic [1:0]  ed;
        for (int p = 0; p < 2; p++) begin
            eb = (ecnt == bus_edge[p]) ? {7'b0, pv[p], !pv[p], pw[p], !pw[p], pa[p], pd[p]} : 64'd0;
            ab = {7'b0, vcs[p], mcs[p], fwr[p], frd[p], faddr[p], fwd[p]};
            ed = (ecnt == done_edge[p]) ? (win[p] ? 2'b10 : 2'b01) : 2'b00;
            chk("bus", p, ab, eb);
            chk("done", p, 64'({done1[p], done0[p]}), 64'(ed));
            chk("busy", p, 64'(busy[p]), 64'(ecnt == bus_edge[p] || ecnt == done_edge[p]));
            chk("m0_rd_data", p, 64'(rd0[p]), 64'(exp_rd[p][0]));
            chk("m1_rd_data", p, 64'(rd1[p]), 64'(exp_rd[p][1]));
            if (done0[p] === 1'b1) begin
                dcnt[p][0]++;
                $display("inst%0d edge %0d: m0 done rd_data=%h", p, ecnt, rd0[p]);
            end
            if (done1[p] === 1'b1) begin
                dcnt[p][1]++;
                $display("inst%0d edge %0d: m1 done rd_data=%h", p, ecnt, rd1[p]);
            end
        end
    endtask

    task automatic step();
        junk = $urandom;
        if (reset_n)
            for (int p = 0; p < 2; p++) model_edge(p, ecnt + 1);
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_payload();
        m0_video = 1'($urandom); m0_wr = 1'($urandom);
        m0_addr = AW'($urandom); m0_wr_data = $urandom;
        m1_video = 1'($urandom); m1_wr = 1'($urandom);
        m1_addr = AW'($urandom); m1_wr_data = $urandom;
    endtask

    int c0, c1;

    initial begin
        m0_req = 0; m0_video = 0; m0_wr = 0; m0_addr = '0; m0_wr_data = '0;
        m1_req = 0; m1_video = 0; m1_wr = 0; m1_addr = '0; m1_wr_data = '0;
        slave_data = '0; junk = '0;
        for (int p = 0; p < 2; p++) begin
            dcnt[p][0] = 0; dcnt[p][1] = 0; win[p] = 0; pv[p] = 0; pw[p] = 0; pa[p] = '0; pd[p] = '0;
        end
        model_reset();
        @(negedge clk);
        step(); step();
        reset_n = 1'b1;

        // m0 MMIO read of 0x10 returning DEADBEEF
        m0_req = 1; m0_video = 0; m0_wr = 0; m0_addr = 21'h000010; slave_data = 32'hDEADBEEF;
        step();
        chk("dir_rd_strobe", 0, 64'({mcs[0], frd[0], vcs[0], fwr[0]}), 64'(4'b1100));
        chk("dir_rd_addr", 0, 64'(faddr[0]), 64'h10);
        m0_req = 0;
        step();
        chk("dir_rd_done", 0, 64'(done0[0]), 64'd1);
        chk("dir_rd_data", 0, 64'(rd0[0]), 64'hDEADBEEF);
        step();

        // m1 video write
        m1_req = 1; m1_video = 1; m1_wr = 1; m1_addr = 21'h100004; m1_wr_data = 32'h12345678;
        step();
        chk("dir_wr_strobe", 0, 64'({vcs[0], fwr[0], mcs[0], frd[0]}), 64'(4'b1100));
        chk("dir_wr_data", 0, 64'(fwd[0]), 64'h12345678);
        m1_req = 0;
        step();
        chk("dir_wr_done", 0, 64'(done1[0]), 64'd1);
        chk("dir_wr_rd1_held", 0, 64'(rd1[0]), 64'd0);
        step();

        // Both held for four transactions
        m0_req = 1; m0_wr = 0; m0_addr = 21'h000020;
        m1_req = 1; m1_wr = 1; m1_addr = 21'h000040;
        c0 = dcnt[0][1]; c1 = dcnt[1][1];
        for (int i = 0; i < 12; i++) begin
            slave_data = $urandom;
            step();
        end
        chk("rr_m1_grants", 0, 64'(dcnt[0][1] - c0), 64'd2);
        chk("fixed_m1_starved", 1, 64'(dcnt[1][1] - c1), 64'd0);
        m0_req = 0;
        for (int i = 0; i < 3; i++) step();
        chk("fixed_m1_after_drop", 1, 64'(dcnt[1][1] - c1), 64'd1);
        m1_req = 0;

        // Reset asserted during GRANT
        m0_req = 1; m1_req = 1;
        step();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        reset_n = 1'b1;
        step();
        chk("post_reset_winner", 0, 64'(faddr[0]), 64'(m0_addr));
        chk("post_reset_winner", 1, 64'(faddr[1]), 64'(m0_addr));
        m0_req = 0; m1_req = 0;
        step(); step();

        // m0 drops request during GRANT
        m0_req = 1;
        step();
        m0_req = 0;
        step();
        chk("drop_done", 0, 64'(done0[0]), 64'd1);
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            m0_req = ($urandom_range(0, 3) != 0);
            m1_req = ($urandom_range(0, 3) != 0);
            rand_payload();
            slave_data = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
